// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package mem_arb_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int DATA_W_DEF       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } grant_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_W_DEF-1:0] data;
    } rsp_buf_t;

endpackage

// File: rtl/mem_rsp_buffer.sv
// Single-entry response holding register: loads on grant, clears when drained.
module mem_rsp_buffer #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              load_err_i,
    input  logic [DWIDTH-1:0] load_data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic              err_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              accept_o
);

    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // A load in the same cycle as a drain wins, keeping one access per cycle.
    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            err_d   = load_err_i;
            data_d  = load_data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            data_d  = '0;
        end
    end

    assign valid_o  = valid_q;
    assign err_o    = err_q;
    assign data_o   = data_q;
    assign accept_o = ~valid_q | ready_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch (I) and load/store (D),
// D-priority with a starvation counter that eventually forces an I grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid_i,
    output logic                i_req_ready_o,
    input  logic [AWIDTH-1:0]   i_req_addr_i,
    output logic                i_rsp_valid_o,
    input  logic                i_rsp_ready_i,
    output logic [DWIDTH-1:0]   i_rsp_data_o,
    output logic                i_rsp_err_o,
    input  logic                d_req_valid_i,
    output logic                d_req_ready_o,
    input  logic                d_req_we_i,
    input  logic [AWIDTH-1:0]   d_req_addr_i,
    input  logic [DWIDTH-1:0]   d_req_wdata_i,
    input  logic [DWIDTH/8-1:0] d_req_strb_i,
    output logic                d_rsp_valid_o,
    input  logic                d_rsp_ready_i,
    output logic [DWIDTH-1:0]   d_rsp_data_o,
    output logic                d_rsp_err_o,
    output logic [AWIDTH-1:0]   mem_addr_o,
    output logic [DWIDTH-1:0]   mem_data_o,
    output logic [DWIDTH/8-1:0] mem_strb_o,
    output logic                mem_read_en_o,
    output logic                mem_write_en_o,
    input  logic [DWIDTH-1:0]   mem_data_i,
    input  logic                mem_vld_i,
    output logic [1:0]          gnt_state_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    grant_state_e state_q, state_d;
    logic [3:0]   starve_q, starve_d;
    logic         gnt_i, gnt_d;
    logic         i_accept, d_accept;
    logic         i_elig, d_elig;
    logic [DWIDTH-1:0] d_load_data;
    logic              d_load_err;

    assign i_elig = i_req_valid_i & i_accept;
    assign d_elig = d_req_valid_i & d_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Grants are suppressed while rst is high so nothing reaches memory.
    always_comb begin
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        state_d  = IDLE;
        starve_d = starve_q;
        if (!rst) begin
            if (i_elig && !(d_elig && (starve_q < LIMIT))) begin
                gnt_i = 1'b1;
            end else if (d_elig) begin
                gnt_d = 1'b1;
            end
        end
        if (gnt_i) begin
            state_d = GNT_I;
        end else if (gnt_d) begin
            state_d = GNT_D;
        end
        // Counter holds while I is blocked by its own full buffer.
        if (gnt_i || !i_req_valid_i) begin
            starve_d = '0;
        end else if (i_elig && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_strb_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (gnt_i) begin
            mem_addr_o    = i_req_addr_i;
            mem_read_en_o = 1'b1;
        end else if (gnt_d) begin
            mem_addr_o = d_req_addr_i;
            if (d_req_we_i) begin
                mem_data_o     = d_req_wdata_i;
                mem_strb_o     = d_req_strb_i;
                mem_write_en_o = 1'b1;
            end else begin
                mem_read_en_o = 1'b1;
            end
        end
    end

    assign d_load_data = d_req_we_i ? '0 : mem_data_i;
    assign d_load_err  = ~d_req_we_i & ~mem_vld_i;

    assign i_req_ready_o = gnt_i;
    assign d_req_ready_o = gnt_d;
    assign gnt_state_o   = state_q;

    mem_rsp_buffer #(.DWIDTH(DWIDTH)) u_i_rsp (
        .clk         (clk),
        .rst         (rst),
        .load_i      (gnt_i),
        .load_err_i  (~mem_vld_i),
        .load_data_i (mem_data_i),
        .ready_i     (i_rsp_ready_i),
        .valid_o     (i_rsp_valid_o),
        .err_o       (i_rsp_err_o),
        .data_o      (i_rsp_data_o),
        .accept_o    (i_accept)
    );

    mem_rsp_buffer #(.DWIDTH(DWIDTH)) u_d_rsp (
        .clk         (clk),
        .rst         (rst),
        .load_i      (gnt_d),
        .load_err_i  (d_load_err),
        .load_data_i (d_load_data),
        .ready_i     (d_rsp_ready_i),
        .valid_o     (d_rsp_valid_o),
        .err_o       (d_rsp_err_o),
        .data_o      (d_rsp_data_o),
        .accept_o    (d_accept)
    );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable unified memory port between instruction fetch (I-port) and load/store unit (D-port).
- Each requester gets a valid/ready request channel and a registered, buffered response channel.
- Arbitration is fixed priority (D over I) with a starvation counter that forces an I grant.
- Memory read is combinational, write commits at posedge; the arbiter sequences one access per cycle.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width; strobe width DWIDTH/8.
- STARVE_LIMIT, 4, consecutive cycles I-port may be denied while requesting before it is forced ahead of D-port (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req_valid_i  in  1  fetch request valid
- i_req_ready_o  out  1  fetch request accepted this cycle
- i_req_addr_i  in  AWIDTH  fetch address
- i_rsp_valid_o  out  1  fetch response valid
- i_rsp_ready_i  in  1  fetch response consumed
- i_rsp_data_o  out  DWIDTH  fetched word
- i_rsp_err_o  out  1  fetch address out of range (memory returned not-valid)
- d_req_valid_i  in  1  load/store request valid
- d_req_ready_o  out  1  load/store request accepted
- d_req_we_i  in  1  1=store, 0=load
- d_req_addr_i  in  AWIDTH  load/store address
- d_req_wdata_i  in  DWIDTH  store data
- d_req_strb_i  in  DWIDTH/8  store byte strobes
- d_rsp_valid_o  out  1  load data / store ack valid
- d_rsp_ready_i  in  1  response consumed
- d_rsp_data_o  out  DWIDTH  load data (0 for stores)
- d_rsp_err_o  out  1  load out of range
- mem_addr_o  out  AWIDTH  to memory addr_i
- mem_data_o  out  DWIDTH  to memory data_i
- mem_strb_o  out  DWIDTH/8  to memory write_strb_i
- mem_read_en_o  out  1  to memory read_en_i
- mem_write_en_o  out  1  to memory write_en_i
- mem_data_i  in  DWIDTH  from memory data_o
- mem_vld_i  in  1  from memory data_vld_o

Behaviour:
- Reset: all rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, starve counter=0, grant state=IDLE; req_ready_o and mem enables combinationally 0 while rst high.
- Eligibility: port X is eligible when X_req_valid_i=1 and its response buffer is empty or is being drained this cycle (X_rsp_valid_o & X_rsp_ready_i).
- Grant, combinational, at most one per cycle:
  - D wins if eligible and starve counter < STARVE_LIMIT.
  - Otherwise I wins if eligible.
  - Otherwise D wins if eligible.
- X_req_ready_o=1 only for the granted port.
- Memory drive: granted port's addr.
  - I grant: read_en=1.
  - D load: read_en=1.
  - D store: write_en=1, data/strb passed through, read_en=0.
  - No grant: both enables 0, addr/data/strb 0.
- Response latency 1 cycle:
  - On grant posedge, load the port's response buffer: data=mem_data_i and err=~mem_vld_i for reads; data=0, err=0 for stores.
  - Set rsp_valid.
  - The buffer holds stable until rsp_ready_i; clear at the posedge where valid&ready and no new grant to that port.
  - Back-to-back grants to the same port sustain 1 access/cycle when rsp_ready_i is held high.
- Grant-state FSM (registered, observable for debug): IDLE, GNT_I, GNT_D. Next state = winner of the current cycle, IDLE if none.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when I is eligible and not granted.
  - Resets to 0 when I is granted or I is not valid.
- Simultaneous requests: at the same cycle D is served and I waits. After STARVE_LIMIT consecutive losses I is served once, then the counter clears.
- Response backpressure: a full, un-drained buffer blocks only its own port; the other port proceeds.
- Reset mid-operation: in-flight responses are discarded. A store granted in the same cycle as reset assertion is not issued (enables forced 0).
- No address or strobe modification in the arbiter; alignment and range checks are done by the memory.

Decomposition:
- Shared package mem_arb_pkg:
  - grant_state_e enum {IDLE, GNT_I, GNT_D}.
  - rsp_buf_t struct {valid, err, data}.
  - Default STARVE_LIMIT constant.
- One natural sub-module: mem_rsp_buffer (single-entry response holding register with load/drain handshake), instantiated twice.

Test Plan:
- I-only fetches to 0x01000000, 0x01000004 with rsp_ready=1 -> ready same cycle; rsp_valid next cycle with the preloaded words; one access per cycle, err=0.
- D store 0xDEADBEEF strb 4'b0011 to 0x01000010, then load 0x01000010 -> store ack data=0; load returns 0x0000BEEF (pre-zeroed memory).
- Both ports valid continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; counter clears after each I grant.
- D load 0x00000000 (below base) -> d_rsp_err=1, d_rsp_data=0; a subsequent valid load has err=0.
- I rsp_ready held 0 for 3 cycles while D issues loads -> I buffer stable, i_req_ready=0, D serviced every cycle; I resumes the cycle after its response is consumed.
- Assert rst while both buffers are valid and a store is presented -> outputs return to reset values immediately; the memory word is unchanged.
